// File: rtl/regfile_pkg.sv
// Shared widths, write-back request payload and address decode helper.
package regfile_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned NUM_REGS = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // One-hot decode of a register address into a register mask.
  function automatic logic [NUM_REGS-1:0] onehot_addr(input logic [ADDR_W-1:0] addr);
    onehot_addr = NUM_REGS'(1) << addr;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back requester handshakes plus the register file write port.
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic                wb0_valid;
  logic [ADDR_W-1:0]   wb0_addr;
  logic [DATA_W-1:0]   wb0_data;
  logic                wb0_ready;
  logic                wb1_valid;
  logic [ADDR_W-1:0]   wb1_addr;
  logic [DATA_W-1:0]   wb1_data;
  logic                wb1_ready;
  logic                RegWrite;
  logic [ADDR_W-1:0]   AddrC;
  logic [DATA_W-1:0]   BusC;
  logic [NUM_REGS-1:0] busy_mask;

  modport master (
    output wb0_valid, wb0_addr, wb0_data, wb1_valid, wb1_addr, wb1_data,
    input  wb0_ready, wb1_ready, RegWrite, AddrC, BusC, busy_mask
  );

  modport slave (
    input  wb0_valid, wb0_addr, wb0_data, wb1_valid, wb1_addr, wb1_data,
    output wb0_ready, wb1_ready, RegWrite, AddrC, BusC, busy_mask
  );

endinterface

// File: rtl/regfile_wb_arbiter_hold_slot.sv
// One-entry hold buffer for a single write-back requester.
module wb_hold_slot
  import regfile_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    flush,
  input  logic    load,
  input  logic    grant,
  input  wb_req_t inReq,
  output logic    slotValid,
  output wb_req_t entry,
  output logic    ready
);

  // Flush wins over a simultaneous load; a grant with a reload keeps the slot full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slotValid <= 1'b0;
      entry     <= '0;
    end else if (flush) begin
      slotValid <= 1'b0;
    end else if (load) begin
      slotValid <= 1'b1;
      entry     <= inReq;
    end else if (grant) begin
      slotValid <= 1'b0;
    end
  end

  // Accept when empty, when being drained this cycle, or while flushing.
  assign ready = !rst && (flush || !slotValid || grant);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-port write-back arbiter feeding the register file's single write port.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter bit ZERO_R0 = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 flush,
  regfile_wb_arbiter_if.slave wb
);

  wb_req_t             req0In, req1In, slot0, slot1, grantReq;
  logic                slot0Valid, slot1Valid;
  logic                ready0, ready1;
  logic                load0, load1;
  logic                grant0, grant1, grantAny, tieGrant;
  logic                next0, next1;
  logic                rrPtr, ageTie, olderPort;
  logic                regWriteQ;
  logic [ADDR_W-1:0]   addrCQ;
  logic [DATA_W-1:0]   busCQ;
  logic [NUM_REGS-1:0] busyMask;

  assign req0In = '{addr: wb.wb0_addr, data: wb.wb0_data};
  assign req1In = '{addr: wb.wb1_addr, data: wb.wb1_data};
  assign load0  = wb.wb0_valid && ready0;
  assign load1  = wb.wb1_valid && ready1;

  wb_hold_slot u_slot0 (
    .clk(clk), .rst(rst), .flush(flush), .load(load0), .grant(grant0),
    .inReq(req0In), .slotValid(slot0Valid), .entry(slot0), .ready(ready0)
  );

  wb_hold_slot u_slot1 (
    .clk(clk), .rst(rst), .flush(flush), .load(load1), .grant(grant1),
    .inReq(req1In), .slotValid(slot1Valid), .entry(slot1), .ready(ready1)
  );

  // Grant the older slot; same-edge loads are resolved by the round-robin pointer.
  always_comb begin
    grant0   = 1'b0;
    grant1   = 1'b0;
    tieGrant = 1'b0;
    if (slot0Valid && slot1Valid) begin
      if (ageTie) begin
        tieGrant = 1'b1;
        grant0   = !rrPtr;
        grant1   = rrPtr;
      end else begin
        grant0   = !olderPort;
        grant1   = olderPort;
      end
    end else if (slot0Valid) begin
      grant0 = 1'b1;
    end else if (slot1Valid) begin
      grant1 = 1'b1;
    end
  end

  assign grantAny = grant0 || grant1;
  assign grantReq = grant1 ? slot1 : slot0;
  assign next0    = load0 || (slot0Valid && !grant0);
  assign next1    = load1 || (slot1Valid && !grant1);

  // Track load order of the two slots and advance the tie-break pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrPtr     <= 1'b0;
      ageTie    <= 1'b0;
      olderPort <= 1'b0;
    end else if (flush) begin
      rrPtr     <= 1'b0;
      ageTie    <= 1'b0;
      olderPort <= 1'b0;
    end else begin
      if (tieGrant) rrPtr <= !rrPtr;
      if (next0 && next1) begin
        if (load0 && load1) begin
          ageTie    <= 1'b1;
          olderPort <= 1'b0;
        end else if (load0) begin
          ageTie    <= 1'b0;
          olderPort <= 1'b1;
        end else if (load1) begin
          ageTie    <= 1'b0;
          olderPort <= 1'b0;
        end
      end else begin
        ageTie    <= 1'b0;
        olderPort <= 1'b0;
      end
    end
  end

  // Registered write port; a hardwired-zero R0 write is consumed but not enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regWriteQ <= 1'b0;
      addrCQ    <= '0;
      busCQ     <= '0;
    end else if (flush) begin
      regWriteQ <= 1'b0;
    end else if (grantAny) begin
      regWriteQ <= !(ZERO_R0 && (grantReq.addr == '0));
      addrCQ    <= grantReq.addr;
      busCQ     <= grantReq.data;
    end else begin
      regWriteQ <= 1'b0;
    end
  end

  // Registers with a write still buffered or in flight to the register file.
  always_comb begin
    busyMask = '0;
    if (slot0Valid) busyMask = busyMask | onehot_addr(slot0.addr);
    if (slot1Valid) busyMask = busyMask | onehot_addr(slot1.addr);
    if (regWriteQ)  busyMask = busyMask | onehot_addr(addrCQ);
    if (ZERO_R0)    busyMask[0] = 1'b0;
  end

  assign wb.wb0_ready = ready0;
  assign wb.wb1_ready = ready1;
  assign wb.RegWrite  = regWriteQ;
  assign wb.AddrC     = addrCQ;
  assign wb.BusC      = busCQ;
  assign wb.busy_mask = busyMask;

endmodule
